flag_tracker: RTL

FLAG_TRACKER -- requirements
Module: flag_tracker

---
 rtl/flag_pkg.sv | 54 +++++
 rtl/flag_mask_fifo.sv | 58 +++++
 rtl/flag_tracker.sv | 119 +++++++++++
 3 files changed

// File: rtl/flag_pkg.sv
// Shared definitions for the flag tracker: group indices, ARM-style
// condition encodings and the condition-to-flag-group mapping.
package flag_pkg;

    // Flag groups; a 3-bit mask uses these bit positions.
    localparam int NGRP = 3;
    localparam int G_NZ = 2;
    localparam int G_CV = 1;
    localparam int G_Q  = 0;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0,
        COND_NE = 4'h1,
        COND_CS = 4'h2,
        COND_CC = 4'h3,
        COND_MI = 4'h4,
        COND_PL = 4'h5,
        COND_VS = 4'h6,
        COND_VC = 4'h7,
        COND_HI = 4'h8,
        COND_LS = 4'h9,
        COND_GE = 4'hA,
        COND_LT = 4'hB,
        COND_GT = 4'hC,
        COND_LE = 4'hD,
        COND_AL = 4'hE,
        COND_NV = 4'hF
    } cond_e;

    // Flag groups a condition field needs to read.
    function automatic logic [NGRP-1:0] cond_groups(input logic [3:0] cond);
        logic [NGRP-1:0] m;
        m = '0;
        case (cond)
            COND_EQ, COND_NE, COND_MI, COND_PL:
                m[G_NZ] = 1'b1;
            COND_CS, COND_CC, COND_VS, COND_VC:
                m[G_CV] = 1'b1;
            COND_HI, COND_LS, COND_GE,
            COND_LT, COND_GT, COND_LE: begin
                m[G_NZ] = 1'b1;
                m[G_CV] = 1'b1;
            end
            default: m = '0;
        endcase
        return m;
    endfunction

    // Expand a group mask onto the 5 flag bits {N,Z,C,V,Q}.
    function automatic logic [4:0] grp_bits(input logic [NGRP-1:0] m);
        return {m[G_NZ], m[G_NZ], m[G_CV], m[G_CV], m[G_Q]};
    endfunction

endpackage

// File: rtl/flag_mask_fifo.sv
// Circular FIFO of group write masks for outstanding long-latency ops.
// Ports: clk, reset, i_push/i_mask, i_pop, o_head, o_full, o_empty.
// Push and pop are expected to be pre-qualified by the caller.
module flag_mask_fifo
    import flag_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_push,
    input  logic [NGRP-1:0] i_mask,
    input  logic            i_pop,
    output logic [NGRP-1:0] o_head,
    output logic            o_full,
    output logic            o_empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [NGRP-1:0] r_mem [DEPTH];
    logic [PW-1:0]   r_wr;
    logic [PW-1:0]   r_rd;
    logic [CW-1:0]   r_cnt;

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr] <= i_mask;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (i_push) begin
                r_wr <= r_wr + PW'(1);
            end
            if (i_pop) begin
                r_rd <= r_rd + PW'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd];
    assign o_full  = (r_cnt == CW'(DEPTH));
    assign o_empty = (r_cnt == '0);

endmodule

// File: rtl/flag_tracker.sv
// Architectural flag register with per-group scoreboard for in-order
// long-latency writers; raises Stall on RAW/WAW hazards at decode.
// Ports: clk/reset; Ex* execute update; Mul* issue/retire of long ops;
// CondValidD/CondD/FlagsWriteD decode query; Flags, Stall, MulFull,
// ProtoErr outputs. Macro FLAG_FWD_EN: Stall sees this cycle's MulDone
// release (zero-bubble); undefined -> Stall uses registered counters.
module flag_tracker
    import flag_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ExValid,
    input  logic [NGRP-1:0] ExFlagsWrite,
    input  logic            ExCondEx,
    input  logic [4:0]      ExALUFlags,
    input  logic            MulIssue,
    input  logic [NGRP-1:0] MulFlagsWrite,
    input  logic            MulDone,
    input  logic            MulCondEx,
    input  logic [4:0]      MulFlags,
    input  logic            CondValidD,
    input  logic [3:0]      CondD,
    input  logic [NGRP-1:0] FlagsWriteD,
    output logic [4:0]      Flags,
    output logic            Stall,
    output logic            MulFull,
    output logic            ProtoErr
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [NGRP-1:0] w_head;
    logic            w_full;
    logic            w_empty;
    logic            w_pop_ok;
    logic            w_push_ok;
    logic            w_err;
    logic [NGRP-1:0] w_inc;
    logic [NGRP-1:0] w_dec;
    logic [NGRP-1:0] w_busy;
    logic [4:0]      w_ex_m;
    logic [4:0]      w_mul_m;
    logic [4:0]      w_flags_nxt;

    logic [CW-1:0]   r_pend [NGRP];
    logic [4:0]      r_flags;
    logic            r_perr;

    // A pop frees a slot, so push+pop while full is accepted.
    assign w_pop_ok  = MulDone & ~w_empty;
    assign w_push_ok = MulIssue & (~w_full | w_pop_ok);
    assign w_err     = (MulIssue & ~w_push_ok) | (MulDone & w_empty);

    assign w_inc = {NGRP{w_push_ok}} & MulFlagsWrite;
    assign w_dec = {NGRP{w_pop_ok}} & w_head;

    flag_mask_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .i_push (w_push_ok),
        .i_mask (MulFlagsWrite),
        .i_pop  (w_pop_ok),
        .o_head (w_head),
        .o_full (w_full),
        .o_empty(w_empty)
    );

    // Ex is the younger writer, so it overrides Mul on shared groups.
    assign w_ex_m  = grp_bits({NGRP{ExValid & ExCondEx}} & ExFlagsWrite);
    assign w_mul_m = grp_bits({NGRP{w_pop_ok & MulCondEx}} & w_head);
    assign w_flags_nxt = (r_flags & ~w_ex_m & ~w_mul_m)
                       | (MulFlags & w_mul_m & ~w_ex_m)
                       | (ExALUFlags & w_ex_m);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int g = 0; g < NGRP; g++) begin
                r_pend[g] <= '0;
            end
            r_flags <= '0;
            r_perr  <= 1'b0;
        end else begin
            for (int g = 0; g < NGRP; g++) begin
                case ({w_inc[g], w_dec[g]})
                    2'b10:   r_pend[g] <= r_pend[g] + CW'(1);
                    2'b01:   r_pend[g] <= r_pend[g] - CW'(1);
                    default: r_pend[g] <= r_pend[g];
                endcase
            end
            r_flags <= w_flags_nxt;
            if (w_err) begin
                r_perr <= 1'b1;
            end
        end
    end

    always_comb begin
        w_busy = '0;
        for (int g = 0; g < NGRP; g++) begin
`ifdef FLAG_FWD_EN
            w_busy[g] = (r_pend[g] != '0) &&
                        !(w_dec[g] && (r_pend[g] == CW'(1)));
`else
            w_busy[g] = (r_pend[g] != '0);
`endif
        end
    end

    assign Stall    = CondValidD &
                      (|((cond_groups(CondD) | FlagsWriteD) & w_busy));
    assign Flags    = r_flags;
    assign MulFull  = w_full;
    assign ProtoErr = r_perr;

endmodule
